// File: rtl/simple_if_mem_pkg.sv
// Shared response codes, FSM state type and saturating-add helper for simple_if_mem.
package simple_if_mem_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {INIT, READY} state_e;

    // Adds a small increment and clamps at maxv; callers narrow the result to their counter width.
    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [1:0] inc,
                                            input logic [63:0] maxv);
        logic [64:0] s;
        s = {1'b0, a} + {63'd0, inc};
        return (s > {1'b0, maxv}) ? maxv : s[63:0];
    endfunction

endpackage

// File: rtl/simple_if_mem_array.sv
// DEPTH x DW storage: one synchronous byte-enabled write port, one asynchronous read port.
module simple_if_mem_array #(
    parameter int DW    = 64,
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk_i,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [DW-1:0]   wdata_i,
    input  logic [DW/8-1:0] wstrb_i,
    input  logic [AW-1:0]   raddr_i,
    output logic [DW-1:0]   rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < DW/8; b++) begin
                if (wstrb_i[b]) mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/simple_if_mem.sv
// Byte-strobed word memory behind the simple interface, with zero-fill on reset and stats counters.
// Define SIMPLE_IF_MEM_RAW_BYPASS_EN to forward same-cycle write data to a read of the same word.
module simple_if_mem
    import simple_if_mem_pkg::*;
#(
    parameter int DW       = 64,
    parameter int MEM_SIZE = 32,
    parameter int DEPTH    = 1024,
    parameter int CNT_W    = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                mem_we_i,
    input  logic [MEM_SIZE-1:0] mem_waddr_i,
    input  logic [DW-1:0]       mem_wdata_i,
    input  logic [DW/8-1:0]     mem_wstrb_i,
    output logic [1:0]          mem_wresp_o,
    input  logic                mem_re_i,
    input  logic [MEM_SIZE-1:0] mem_raddr_i,
    output logic [DW-1:0]       mem_rdata_o,
    output logic [1:0]          mem_rresp_o,
    output logic                init_done_o,
    output logic [CNT_W-1:0]    wr_cnt_o,
    output logic [CNT_W-1:0]    rd_cnt_o,
    output logic [CNT_W-1:0]    err_cnt_o
);

    localparam int NB  = DW / 8;
    localparam int OFF = $clog2(NB);
    localparam int AW  = $clog2(DEPTH);
    localparam logic [63:0] CNT_MAX = 64'({CNT_W{1'b1}});

    state_e            state_q, state_d;
    logic [AW-1:0]     init_idx_q, init_idx_d;
    logic              init_done_q, init_done_d;
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d, err_cnt_q, err_cnt_d;

    logic [MEM_SIZE-1:0] widx, ridx;
    logic                w_in, r_in, active, w_ok, r_ok, w_err, r_err, init_fill;
    logic                arr_we;
    logic [AW-1:0]       arr_waddr;
    logic [DW-1:0]       arr_wdata, arr_rdata, rd_word;
    logic [NB-1:0]       arr_wstrb;

    // Range check on the full-width word index so high address bits cannot alias into the array.
    assign widx   = mem_waddr_i >> OFF;
    assign ridx   = mem_raddr_i >> OFF;
    assign w_in   = widx < MEM_SIZE'(DEPTH);
    assign r_in   = ridx < MEM_SIZE'(DEPTH);
    assign active = (state_q == READY) && !rst_i;
    assign w_ok   = mem_we_i && active && w_in;
    assign r_ok   = mem_re_i && active && r_in;
    assign w_err  = mem_we_i && !rst_i && !w_ok;
    assign r_err  = mem_re_i && !rst_i && !r_ok;

    assign init_fill = (state_q == INIT) && !rst_i;
    assign arr_we    = init_fill || w_ok;
    assign arr_waddr = init_fill ? init_idx_q : widx[AW-1:0];
    assign arr_wdata = init_fill ? '0 : mem_wdata_i;
    assign arr_wstrb = init_fill ? '1 : mem_wstrb_i;

    simple_if_mem_array #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_array (
        .clk_i   (clk_i),
        .we_i    (arr_we),
        .waddr_i (arr_waddr),
        .wdata_i (arr_wdata),
        .wstrb_i (arr_wstrb),
        .raddr_i (ridx[AW-1:0]),
        .rdata_o (arr_rdata)
    );

    always_comb begin
        rd_word = arr_rdata;
`ifdef SIMPLE_IF_MEM_RAW_BYPASS_EN
        if (w_ok && r_ok && (widx == ridx)) begin
            for (int b = 0; b < NB; b++) begin
                if (mem_wstrb_i[b]) rd_word[b*8 +: 8] = mem_wdata_i[b*8 +: 8];
            end
        end
`endif
    end

    always_comb begin
        mem_wresp_o = (rst_i || w_err) ? RESP_SLVERR : RESP_OKAY;
        mem_rresp_o = (rst_i || r_err) ? RESP_SLVERR : RESP_OKAY;
        mem_rdata_o = r_ok ? rd_word : '0;
    end

    always_comb begin
        state_d     = state_q;
        init_idx_d  = init_idx_q;
        init_done_d = init_done_q;
        if (state_q == INIT) begin
            init_idx_d = init_idx_q + AW'(1);
            if (init_idx_q == AW'(DEPTH - 1)) begin
                state_d     = READY;
                init_done_d = 1'b1;
                init_idx_d  = '0;
            end
        end
        wr_cnt_d  = CNT_W'(sat_add(64'(wr_cnt_q), {1'b0, w_ok}, CNT_MAX));
        rd_cnt_d  = CNT_W'(sat_add(64'(rd_cnt_q), {1'b0, r_ok}, CNT_MAX));
        err_cnt_d = CNT_W'(sat_add(64'(err_cnt_q), {1'b0, w_err} + {1'b0, r_err}, CNT_MAX));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= INIT;
            init_idx_q  <= '0;
            init_done_q <= 1'b0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            init_idx_q  <= init_idx_d;
            init_done_q <= init_done_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign init_done_o = init_done_q;
    assign wr_cnt_o    = wr_cnt_q;
    assign rd_cnt_o    = rd_cnt_q;
    assign err_cnt_o   = err_cnt_q;

endmodule
